// File: rtl/calc_arbiter_if.sv
// calc_arbiter_if: the requester/datapath bundle around calc_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// requesters plus datapath, which the testbench drives.
// Operand and result vectors are two's-complement WIDTH-bit values.
// The arbiter only moves them, so they are carried as plain vectors.
interface calc_arbiter_if #(
  parameter int WIDTH = 8
);
  // requester side
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic             gnt0;
  logic             gnt1;
  logic             valid0;
  logic             valid1;
  logic [WIDTH-1:0] result;
  logic             err;

  // datapath side
  logic             done;
  logic [WIDTH-1:0] res;
  logic             sel;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [1:0]       op_out;
  logic             start;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, done, res,
    output sel, a_out, b_out, op_out, start, gnt0, gnt1,
           valid0, valid1, result, err
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, done, res,
    input  sel, a_out, b_out, op_out, start, gnt0, gnt1,
           valid0, valid1, result, err
  );
endinterface

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin arbiter that lets two requesters share one
// calculator datapath.
// The FSM moves IDLE -> ISSUE -> WAIT -> DONE.
// - The winner's operands are latched on leaving IDLE.
// - start pulses in ISSUE.
// - In WAIT the arbiter waits for done and captures res.
// - In DONE the served requester gets its valid pulse.
// Optional feature: define CALC_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles. The abort raises a one-cycle err pulse and gives no valid.
module calc_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  calc_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic             ptr;
  logic             sel;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [1:0]       op_out;
  logic             start;
  logic             gnt0;
  logic             gnt1;
  logic             valid0;
  logic             valid1;
  logic [WIDTH-1:0] result;
  logic             win;

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] tmo_cnt;
  logic          err;
`else
  // The timeout depth matters only when the timeout feature is built in.
  if (TIMEOUT > 0) begin : g_timeout_unused
  end
`endif

  // A lone request wins. When both request, ptr picks the winner.
  assign win = (bus.req0 && bus.req1) ? ptr : bus.req1;

  // Main FSM. All outputs are registered and change on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      sel    <= 1'b0;
      a_out  <= '0;
      b_out  <= '0;
      op_out <= '0;
      start  <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      result <= '0;
`ifdef CALC_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      err     <= 1'b0;
`endif
    end else begin
      start  <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state  <= ISSUE;
            sel    <= win;
            a_out  <= win ? bus.a1  : bus.a0;
            b_out  <= win ? bus.b1  : bus.b0;
            op_out <= win ? bus.op1 : bus.op0;
            start  <= 1'b1;
            gnt0   <= ~win;
            gnt1   <= win;
          end
        end
        ISSUE: begin
          // done is deliberately ignored here; the datapath has only just
          // seen start.
          state <= WAIT;
`ifdef CALC_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.done) begin
            state  <= DONE;
            result <= bus.res;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            ptr    <= ~sel;
            valid0 <= ~sel;
            valid1 <= sel;
`ifdef CALC_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: result is left as it was and no valid is raised.
            state   <= DONE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ptr     <= ~sel;
            err     <= 1'b1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel    = sel;
  assign bus.a_out  = a_out;
  assign bus.b_out  = b_out;
  assign bus.op_out = op_out;
  assign bus.start  = start;
  assign bus.gnt0   = gnt0;
  assign bus.gnt1   = gnt1;
  assign bus.valid0 = valid0;
  assign bus.valid1 = valid1;
  assign bus.result = result;
`ifdef CALC_ARB_TIMEOUT_EN
  assign bus.err    = err;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed test of calc_arbiter with hand-computed
// expectations.
// Inputs change after the sampling point. Outputs are sampled 1 ns after
// the rising edge.
// The timeout scenario follows CALC_ARB_TIMEOUT_EN.
module tb_calc_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  calc_arbiter_if #(.WIDTH(8)) bus ();

  calc_arbiter #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the expected value and log any mismatch.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // gnt0 and gnt1 must never be high together.
  task automatic check_excl(input string tag);
    check_val(tag, {31'b0, bus.gnt0 & bus.gnt1}, 32'd0);
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.done = 0; bus.res = 0;

    // Reset values.
    #12;
    check_val("rst_gnt0", {31'b0, bus.gnt0}, 32'd0);
    check_val("rst_start", {31'b0, bus.start}, 32'd0);
    check_val("rst_sel", {31'b0, bus.sel}, 32'd0);
    check_val("rst_result", {24'b0, bus.result}, 32'd0);
    check_val("rst_err", {31'b0, bus.err}, 32'd0);
    do_reset();

    // Single request: 5, -3, op 0. done arrives 2 cycles after start and returns 2.
    bus.req0 = 1; bus.a0 = 8'd5; bus.b0 = 8'hFD; bus.op0 = 2'd0;
    bus.a1 = 8'd77; bus.b1 = 8'd66; bus.op1 = 2'd3;
    tick();  // ISSUE
    check_val("s_start", {31'b0, bus.start}, 32'd1);
    check_val("s_gnt0", {31'b0, bus.gnt0}, 32'd1);
    check_val("s_gnt1", {31'b0, bus.gnt1}, 32'd0);
    check_val("s_sel", {31'b0, bus.sel}, 32'd0);
    check_val("s_a_out", {24'b0, bus.a_out}, 32'h05);
    check_val("s_b_out", {24'b0, bus.b_out}, 32'hFD);
    check_val("s_op_out", {30'b0, bus.op_out}, 32'd0);
    bus.req0 = 0;  // dropping req must not abort
    tick();  // WAIT
    check_val("s_start_off", {31'b0, bus.start}, 32'd0);
    check_val("s_gnt0_wait", {31'b0, bus.gnt0}, 32'd1);
    tick();  // WAIT
    check_val("s_valid0_early", {31'b0, bus.valid0}, 32'd0);
    check_val("s_a_out_hold", {24'b0, bus.a_out}, 32'h05);
    bus.done = 1; bus.res = 8'd2;
    tick();  // DONE
    bus.done = 0;
    check_val("s_valid0", {31'b0, bus.valid0}, 32'd1);
    check_val("s_valid1", {31'b0, bus.valid1}, 32'd0);
    check_val("s_result", {24'b0, bus.result}, 32'd2);
    check_val("s_gnt0_done", {31'b0, bus.gnt0}, 32'd0);
    check_val("s_b_out_hold", {24'b0, bus.b_out}, 32'hFD);
    tick();  // IDLE
    check_val("s_valid0_off", {31'b0, bus.valid0}, 32'd0);

    // Both requesters held high after reset: grants go 0,1,0,1.
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.a0 = 8'd10; bus.a1 = 8'd20;
    for (int k = 0; k < 4; k++) begin
      automatic logic w = k[0];
      tick();  // ISSUE
      check_val($sformatf("rr%0d_gnt0", k), {31'b0, bus.gnt0}, {31'b0, ~w});
      check_val($sformatf("rr%0d_gnt1", k), {31'b0, bus.gnt1}, {31'b0, w});
      check_val($sformatf("rr%0d_sel", k), {31'b0, bus.sel}, {31'b0, w});
      check_val($sformatf("rr%0d_a_out", k), {24'b0, bus.a_out}, w ? 32'd20 : 32'd10);
      check_excl($sformatf("rr%0d_excl", k));
      tick();  // WAIT
      check_excl($sformatf("rr%0d_excl_w", k));
      bus.done = 1; bus.res = 8'(k + 10);
      tick();  // DONE
      bus.done = 0;
      check_val($sformatf("rr%0d_valid0", k), {31'b0, bus.valid0}, {31'b0, ~w});
      check_val($sformatf("rr%0d_valid1", k), {31'b0, bus.valid1}, {31'b0, w});
      check_val($sformatf("rr%0d_result", k), {24'b0, bus.result}, 32'(k + 10));
      tick();  // IDLE
      check_val($sformatf("rr%0d_idle_gnt", k), {30'b0, bus.gnt1, bus.gnt0}, 32'd0);
    end
    bus.req0 = 0; bus.req1 = 0;

    // A done pulse while IDLE or ISSUE has no effect.
    bus.done = 1; bus.res = 8'd99;
    tick();
    bus.done = 0;
    check_val("di_gnt", {30'b0, bus.gnt1, bus.gnt0}, 32'd0);
    check_val("di_valid", {30'b0, bus.valid1, bus.valid0}, 32'd0);
    check_val("di_result", {24'b0, bus.result}, 32'd13);
    bus.req1 = 1; bus.a1 = 8'd3;
    tick();  // ISSUE
    bus.req1 = 0;
    bus.done = 1; bus.res = 8'd88;
    tick();  // WAIT: the done seen in ISSUE is ignored
    bus.done = 0;
    check_val("dx_gnt1", {31'b0, bus.gnt1}, 32'd1);
    check_val("dx_valid1", {31'b0, bus.valid1}, 32'd0);
    check_val("dx_result", {24'b0, bus.result}, 32'd13);
    bus.done = 1; bus.res = 8'hFC;
    tick();  // DONE
    bus.done = 0;
    check_val("dx_valid1_done", {31'b0, bus.valid1}, 32'd1);
    check_val("dx_result_done", {24'b0, bus.result}, 32'hFC);
    tick();  // IDLE, ptr now 0

    // Reset during WAIT: first serve requester 0 so ptr=1, then abort requester 1.
    bus.req0 = 1;
    tick(); bus.req0 = 0;
    tick();
    bus.done = 1; bus.res = 8'd33;
    tick(); bus.done = 0;
    tick();  // IDLE, ptr=1
    bus.req1 = 1; bus.a1 = 8'd44; bus.op1 = 2'd2;
    tick();  // ISSUE
    check_val("ra_gnt1", {31'b0, bus.gnt1}, 32'd1);
    bus.req1 = 0;
    tick();  // WAIT
    bus.done = 1; bus.res = 8'd55;
    #2 rst_n = 1'b0;
    #1;
    check_val("ra_gnt", {30'b0, bus.gnt1, bus.gnt0}, 32'd0);
    check_val("ra_sel", {31'b0, bus.sel}, 32'd0);
    check_val("ra_a_out", {24'b0, bus.a_out}, 32'd0);
    check_val("ra_op_out", {30'b0, bus.op_out}, 32'd0);
    check_val("ra_result", {24'b0, bus.result}, 32'd0);
    bus.done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val($sformatf("ra_post%0d_valid", k), {30'b0, bus.valid1, bus.valid0}, 32'd0);
      check_val($sformatf("ra_post%0d_err", k), {31'b0, bus.err}, 32'd0);
    end
    bus.req0 = 1; bus.req1 = 1;
    tick();  // ISSUE: ptr was reset, so requester 0 wins
    check_val("ra_next_gnt0", {31'b0, bus.gnt0}, 32'd1);
    check_val("ra_next_gnt1", {31'b0, bus.gnt1}, 32'd0);
    check_val("ra_next_sel", {31'b0, bus.sel}, 32'd0);
    bus.req0 = 0; bus.req1 = 0;
    tick();  // WAIT, done never arrives

`ifdef CALC_ARB_TIMEOUT_EN
    for (int k = 0; k < 14; k++) begin
      tick();
      check_val($sformatf("to%0d_err", k), {31'b0, bus.err}, 32'd0);
      check_val($sformatf("to%0d_gnt0", k), {31'b0, bus.gnt0}, 32'd1);
    end
    tick();  // 15th WAIT cycle -> DONE with err
    check_val("to_err", {31'b0, bus.err}, 32'd1);
    check_val("to_valid", {30'b0, bus.valid1, bus.valid0}, 32'd0);
    check_val("to_gnt0", {31'b0, bus.gnt0}, 32'd0);
    check_val("to_result", {24'b0, bus.result}, 32'd0);
    tick();  // IDLE
    check_val("to_err_off", {31'b0, bus.err}, 32'd0);
    check_val("to_valid_off", {30'b0, bus.valid1, bus.valid0}, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      check_val($sformatf("nt%0d_err", k), {31'b0, bus.err}, 32'd0);
      check_val($sformatf("nt%0d_gnt0", k), {31'b0, bus.gnt0}, 32'd1);
    end
    bus.done = 1; bus.res = 8'd7;
    tick();
    bus.done = 0;
    check_val("nt_valid0", {31'b0, bus.valid0}, 32'd1);
    check_val("nt_result", {24'b0, bus.result}, 32'd7);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit on the whole run.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the signed operand/result width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the max WAIT cycles before abort (used only with CALC_ARB_TIMEOUT_EN).
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Ports req0, req1  input  1 each  SHALL be the request lines from requester 0 and requester 1.
REQ-006 Ports a0, b0, a1, b1  input  WIDTH each  SHALL be the signed operands of each requester.
REQ-007 Ports op0, op1  input  2 each  SHALL be the calculator opcode of each requester.
REQ-008 Port done  input  1  SHALL be the datapath completion strobe.
REQ-009 Port res  input  WIDTH  SHALL be the datapath result, valid when done=1.
REQ-010 Port sel  output  1  SHALL drive the operand 2:1 mux select (0=requester 0, 1=requester 1).
REQ-011 Ports a_out, b_out  output  WIDTH; op_out  output  2  SHALL be the latched operands/opcode to the datapath.
REQ-012 Port start  output  1  SHALL be the one-cycle datapath start pulse.
REQ-013 Ports gnt0, gnt1  output  1 each  SHALL be the grant lines.
REQ-014 Ports valid0, valid1  output  1 each  SHALL be one-cycle result-ready pulses.
REQ-015 Port result  output  WIDTH  SHALL hold the last captured res.
REQ-016 Port err  output  1  SHALL be a one-cycle timeout pulse.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE SHALL be used; req0/req1 SHALL be sampled only in IDLE.
REQ-018 IDLE: any req high SHALL latch sel, a_out, b_out, op_out from the winner and go to ISSUE next edge; no req SHALL stay IDLE.
REQ-019 Arbitration: single request wins; both high SHALL go to the requester named by the round-robin pointer ptr.
REQ-020 ptr SHALL toggle to the non-served requester on entry to DONE, giving strict alternation under continuous dual requests.
REQ-021 ISSUE: start=1 for exactly one cycle, then WAIT unconditionally; done in ISSUE SHALL be ignored.
REQ-022 gnt of the winner SHALL be high in ISSUE and WAIT only; gnt0 and gnt1 SHALL never be high together.
REQ-023 WAIT: done=1 SHALL capture res into result and go to DONE; otherwise remain WAIT.
REQ-024 DONE: valid of the served requester SHALL pulse one cycle, then return to IDLE; min request-to-valid latency is 3 edges (done in first WAIT cycle).
REQ-025 sel, a_out, b_out, op_out SHALL remain stable from ISSUE through DONE.
REQ-026 Requester dropping req during ISSUE/WAIT SHALL NOT abort the operation; valid SHALL still pulse.
REQ-027 done outside WAIT SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, ptr=0, sel=0, start=0, gnt0=gnt1=0, valid0=valid1=0, err=0, a_out=b_out=result=0, op_out=0, timeout counter=0.
REQ-029 Reset mid-operation SHALL discard the operation with no valid or err pulse after release.

Configuration
REQ-030 Macro CALC_ARB_TIMEOUT_EN defined: a counter SHALL count WAIT cycles; reaching TIMEOUT without done SHALL go to DONE with err=1 for one cycle, no valid pulse, result unchanged, ptr toggled.
REQ-031 Macro CALC_ARB_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, err SHALL be constant 0, no counter logic.

Verification
REQ-032 req0=1 only, a0=5, b0=-3, op0=0, done 2 cycles after start, res=2 -> sel=0, gnt0 in ISSUE/WAIT, start one cycle, valid0 one pulse, result=2.
REQ-033 req0=req1=1 held, after reset -> grants order 0,1,0,1; sel tracks; no overlapping gnt.
REQ-034 done pulsed while IDLE and during ISSUE -> no state change, no valid, result unchanged.
REQ-035 rst_n low during WAIT with done pending -> all outputs at reset values, no valid after release, next grant to requester 0.
REQ-036 With CALC_ARB_TIMEOUT_EN, TIMEOUT=15, done never asserted -> err pulses after 15 WAIT cycles, no valid, FSM back to IDLE; without macro, FSM stays WAIT, err=0.
